// File: rtl/reg_writeback_pkg.sv
// Shared constants for the register-file writeback block.
package reg_writeback_pkg;
  localparam int XLEN         = 32;
  localparam int AW           = 5;
  localparam int NREG         = 1 << AW;
  localparam int STARVE_LIMIT = 4;
  localparam int REG_X0       = 0;

  localparam logic RF_WREN_ON  = 1'b0;
  localparam logic RF_WREN_OFF = 1'b1;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_MEM  = 2'd2
  } wb_src_e;
endpackage

// File: rtl/reg_writeback_if.sv
// Result sources, issue/decode hooks and register-file write port of the writeback block.
interface reg_writeback_if #(
  parameter int XLEN = reg_writeback_pkg::XLEN,
  parameter int AW   = reg_writeback_pkg::AW
);
  logic            alu_valid;
  logic            alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid;
  logic            mem_ready;
  logic [AW-1:0]   mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic [AW-1:0]   rs_addr1;
  logic [AW-1:0]   rs_addr2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            rf_wren;
  logic [AW-1:0]   rf_rd_addr;
  logic [XLEN-1:0] rf_wr;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           iss_valid, iss_rd, rs_addr1, rs_addr2,
    input  alu_ready, mem_ready, rs1_busy, rs2_busy, rf_wren, rf_rd_addr, rf_wr
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           iss_valid, iss_rd, rs_addr1, rs_addr2,
    output alu_ready, mem_ready, rs1_busy, rs2_busy, rf_wren, rf_rd_addr, rf_wr
  );
endinterface

// File: rtl/reg_writeback_wb_scoreboard.sv
// Pending-write vector: one bit per architectural register, x0 never pending.
module wb_scoreboard #(
  parameter int AW = reg_writeback_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] rd_idx1,
  input  logic [AW-1:0] rd_idx2,
  output logic          busy1,
  output logic          busy2
);
  import reg_writeback_pkg::*;

  localparam int NR = 1 << AW;

  logic [NR-1:1] pend_q;
  logic [NR-1:0] pending;

  // Set is checked after clear so a same-edge re-issue keeps the bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
    end else begin
      for (int r = 1; r < NR; r++) begin
        if (clr_en && clr_idx == AW'(r)) pend_q[r] <= 1'b0;
        if (set_en && set_idx == AW'(r)) pend_q[r] <= 1'b1;
      end
    end
  end

  assign pending = {pend_q, 1'b0};
  assign busy1   = pending[rd_idx1];
  assign busy2   = pending[rd_idx2];
endmodule

// File: rtl/reg_writeback.sv
// Arbitrates ALU and load results onto the single register-file write port and
// tracks in-flight destinations for decode hazard stalls.
module reg_writeback #(
  parameter int XLEN         = reg_writeback_pkg::XLEN,
  parameter int AW           = reg_writeback_pkg::AW,
  parameter int STARVE_LIMIT = reg_writeback_pkg::STARVE_LIMIT
) (
  input  logic            clk,
  input  logic            rst,
  reg_writeback_if.slave  wb
);
  import reg_writeback_pkg::*;

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  logic [CW-1:0]   starve_cnt;
  logic            alu_pri;
  logic            alu_acc;
  logic            mem_acc;
  wb_src_e         src;
  wb_req_t         sel;
  logic            rf_wren_q;
  logic [AW-1:0]   rf_addr_q;
  logic [XLEN-1:0] rf_data_q;

  // MEM normally wins; ALU gets one slot after STARVE_LIMIT refusals in a row.
  assign alu_pri      = (starve_cnt == CW'(STARVE_LIMIT));
  assign wb.mem_ready = ~(wb.alu_valid & alu_pri);
  assign wb.alu_ready = ~wb.mem_valid | alu_pri;
  assign mem_acc      = wb.mem_valid & wb.mem_ready;
  assign alu_acc      = wb.alu_valid & wb.alu_ready;

  always_comb begin
    src = SRC_NONE;
    sel = '{rd: wb.mem_rd, data: wb.mem_data};
    if (mem_acc) begin
      src = SRC_MEM;
    end else if (alu_acc) begin
      src = SRC_ALU;
      sel = '{rd: wb.alu_rd, data: wb.alu_data};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!wb.alu_valid || alu_acc) begin
      starve_cnt <= '0;
    end else if (!alu_pri) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // x0 results are consumed but never drive the write strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_wren_q <= RF_WREN_OFF;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      rf_wren_q <= (src != SRC_NONE && sel.rd != AW'(REG_X0)) ? RF_WREN_ON : RF_WREN_OFF;
      if (src != SRC_NONE) begin
        rf_addr_q <= sel.rd;
        rf_data_q <= sel.data;
      end
    end
  end

  assign wb.rf_wren    = rf_wren_q;
  assign wb.rf_rd_addr = rf_addr_q;
  assign wb.rf_wr      = rf_data_q;

  wb_scoreboard #(.AW(AW)) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (wb.iss_valid),
    .set_idx (wb.iss_rd),
    .clr_en  (rf_wren_q == RF_WREN_ON),
    .clr_idx (rf_addr_q),
    .rd_idx1 (wb.rs_addr1),
    .rd_idx2 (wb.rs_addr2),
    .busy1   (wb.rs1_busy),
    .busy2   (wb.rs2_busy)
  );
endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Writer side of the 32x32 register file.
- Arbitrates result writes from the ALU path and the load (MEM) path onto the file's single write port, one write per cycle.
- Keeps a pending-write scoreboard so decode can stall on RAW hazards against rs1/rs2.
- Sits between execute/memory stages and the register file write port (rf_wren active-low, rf_rd_addr, rf_wr).

Parameters:
XLEN, 32, data width
AW, 5, register address width (NREG = 2**AW)
STARVE_LIMIT, 4, consecutive cycles ALU may be refused before it wins priority once

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous active-low reset (negedge rst)
alu_valid  in  1  ALU result present
alu_ready  out  1  ALU result accepted this cycle (valid & ready)
alu_rd  in  AW  ALU destination
alu_data  in  XLEN  ALU result
mem_valid  in  1  load result present
mem_ready  out  1  load result accepted this cycle
mem_rd  in  AW  load destination
mem_data  in  XLEN  load data
iss_valid  in  1  instruction with destination issued this cycle
iss_rd  in  AW  its destination
rs_addr1  in  AW  decode operand 1 address
rs_addr2  in  AW  decode operand 2 address
rs1_busy  out  1  operand 1 has a pending write
rs2_busy  out  1  operand 2 has a pending write
rf_wren  out  1  register file write enable, active-low (0 = write)
rf_rd_addr  out  AW  register file write address
rf_wr  out  XLEN  register file write data

Behaviour:
- Reset (rst=0, async): rf_wren=1, rf_rd_addr=0, rf_wr=0, pending=0, starve_cnt=0. rst asserted mid-transfer drops any accepted-but-unwritten result. The result is lost; no write occurs.
- Arbitration (combinational ready):
  - Default priority is MEM over ALU.
  - mem_ready = ~(alu_valid & alu_pri); alu_ready = ~mem_valid | alu_pri.
  - alu_pri = (starve_cnt == STARVE_LIMIT).
  - Ready is independent of its own valid; a source with valid=0 may still see ready=1.
- Starvation counter:
  - Increments when alu_valid & ~alu_ready.
  - Clears to 0 on any ALU acceptance, or when alu_valid=0.
  - Saturates at STARVE_LIMIT.
- Output stage (1-cycle latency): at the edge where a source is accepted, rf_rd_addr/rf_wr load its rd/data. rf_wren=0 for that one following cycle, so the file writes at the next edge.
- No acceptance: rf_wren=1; rf_rd_addr/rf_wr hold their last values.
- x0: an accepted result with rd=0 is consumed (ready handshake completes) but rf_wren stays 1. No x0 write is ever issued.
- Scoreboard: pending[NREG-1:0], bit 0 hard-wired 0.
  - Set: at posedge with iss_valid & iss_rd!=0, pending[iss_rd]<=1.
  - Clear: at posedge with rf_wren==0, pending[rf_rd_addr]<=0. This is the same edge the file captures the data.
  - Same register set and cleared at the same edge: set wins (the younger issue).
- Busy outputs: rs1_busy = pending[rs_addr1]; rs2_busy = pending[rs_addr2]. Purely combinational from state, so no comb path from the valid inputs. The cycle after rf_wren=0 the file holds the data and busy is already 0.
- Results to a register whose pending bit is 0 are still written. The scoreboard is advisory only; there is no protocol check.
- Both sources valid every cycle: MEM wins STARVE_LIMIT cycles, then ALU wins 1 cycle, and the pattern repeats.

Decomposition:
- Shared package holds XLEN, AW, NREG, the RF_WREN_ON=1'b0 / RF_WREN_OFF=1'b1 constants, and the x0 index constant.
- One sub-module, wb_scoreboard, covers the pending vector: set/clear ports plus two read ports.
- Arbitration, the starvation counter and the output register stay in reg_writeback.

Test Plan:
- Reset: hold rst=0 with all valids high -> rf_wren=1, rf_rd_addr=0, rf_wr=0, rs1_busy=rs2_busy=0. Release rst -> first acceptance occurs on the first clock edge.
- Single ALU write: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for 1 cycle -> alu_ready=1. Next cycle rf_wren=0, rf_rd_addr=5, rf_wr=0xDEADBEEF. Cycle after, rf_wren=1.
- Conflict and starvation: alu_valid=mem_valid=1 held for 10 cycles (STARVE_LIMIT=4) -> mem accepted in cycles 0-3, alu in 4, mem in 5-8, alu in 9. rf_wren=0 every cycle from cycle 1.
- x0 suppression: mem_valid=1, mem_rd=0, mem_data=0x1234 -> mem_ready=1, rf_wren stays 1, pending[0] and rs1_busy for rs_addr1=0 remain 0.
- Scoreboard: iss_valid=1, iss_rd=7, then rs_addr1=7 -> rs1_busy=1 until the edge where rf_wren=0 with rf_rd_addr=7, then 0. Re-issuing iss_rd=7 on that same edge -> rs1_busy stays 1.
- Reset mid-transfer: ALU accepted (rd=3), rst pulsed low before the write edge -> rf_wren=1 throughout, pending[3]=0 after reset.
